imem_boot_arbiter: RTL and testbench
====================================

IMEM_BOOT_ARBITER -- requirements
Module: imem_boot_arbiter

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, meaning the instruction memory capacity in 32-bit words (power of two, 4..65536).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
REQ-004 start  input  1  request to begin (or restart) an image load.
REQ-005 load_valid  input  1  loader word available on load_data.
REQ-006 load_data  input  32  instruction word to store.
REQ-007 load_last  input  1  marks the accepted word as the final word of the image.
REQ-008 load_ready  output  1  block can accept a loader word this cycle.
REQ-009 pc_addr  input  32  fetch-stage PC (byte address).
REQ-010 mem_rdata  input  32  combinational read data from instruction memory.
REQ-011 mem_we  output  1  instruction memory write enable.
REQ-012 mem_addr  output  32  instruction memory byte address.
REQ-013 mem_wdata  output  32  instruction memory write data.
REQ-014 instr_out  output  32  instruction delivered to fetch stage.
REQ-015 cpu_run  output  1  fetch stage enable (PC advance permitted).
REQ-016 load_count  output  16  number of words accepted in the current/last load.
REQ-017 err  output  1  sticky overflow error flag.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, DRAIN, RUN, ERROR; state encoding is implementer's choice.
REQ-019 IDLE: load_ready=0, cpu_run=0, mem_we=0; start=1 -> LOAD, write pointer and load_count cleared to 0.
REQ-020 LOAD: load_ready=1; a word is accepted when load_valid=1 and load_ready=1 on a rising edge.
REQ-021 Accepted word SHALL be written one cycle later: mem_we=1, mem_addr={wptr,2'b00}, mem_wdata=load_data, all registered.
REQ-022 Each acceptance increments write pointer and load_count by 1; no acceptance -> mem_we=0 next cycle.
REQ-023 Acceptance with load_last=1 -> DRAIN; load_ready=0 from the following cycle.
REQ-024 Acceptance without load_last when wptr=DEPTH_WORDS-1 -> word is still written, then ERROR.
REQ-025 DRAIN: exactly one cycle (final registered write completes), load_ready=0, cpu_run=0, then RUN.
REQ-026 RUN: cpu_run=1, load_ready=0, mem_we=0, mem_addr=pc_addr (combinational pass-through), instr_out=mem_rdata.
REQ-027 In every state other than RUN, instr_out SHALL be 32'h00000000 and cpu_run SHALL be 0.
REQ-028 start=1 in RUN -> LOAD next cycle (reload); cpu_run drops to 0 in that cycle; pointer and load_count cleared.
REQ-029 start during LOAD or DRAIN SHALL be ignored.
REQ-030 load_valid outside LOAD SHALL be ignored; no write, no count change.
REQ-031 ERROR: err=1, cpu_run=0, load_ready=0, mem_we=0; exit only via reset; start ignored.
REQ-032 In non-RUN states with mem_we=0, mem_addr SHALL hold its last registered value.
REQ-033 load_count saturates at 16'hFFFF; it holds after DRAIN/RUN until the next reload.

Reset
REQ-034 rst=0 SHALL force IDLE and outputs: load_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_out=0, cpu_run=0, load_count=0, err=0.
REQ-035 Reset asserted mid-LOAD SHALL abort the load with no further write; mem_we=0 immediately.
REQ-036 After rst returns to 1, the block SHALL remain in IDLE until start=1.

Verification
REQ-037 Reset, start, load 3 words (0x00500093, 0x00100113, 0x002081B3, last on 3rd) -> writes at 0x0,0x4,0x8 one cycle after each accept; DRAIN 1 cycle; cpu_run=1; load_count=3.
REQ-038 RUN, pc_addr=0x4, mem_rdata=0x00100113 -> instr_out=0x00100113, mem_addr=0x4 same cycle, mem_we=0.
REQ-039 LOAD with load_valid toggling 1,0,1 -> exactly 2 writes, no write in gap cycle, addresses 0x0 then 0x4.
REQ-040 DEPTH_WORDS=4, 5 words without load_last -> 4 writes (0x0..0xC), err=1, cpu_run stays 0, start ignored.
REQ-041 Reset asserted after 2 accepted words of a load -> all outputs 0 asynchronously, state IDLE, no 3rd write.
REQ-042 start=1 while in RUN -> cpu_run=0 next cycle, load_count=0, reload of 1 word (last) -> RUN again, load_count=1.

Source files
------------

// File: rtl/imem_boot_arbiter.sv
// Instruction-memory boot arbiter.
// A loader streams an image into instruction memory through registered writes.
// Once the image is complete, memory ownership passes to the fetch stage,
// with PC pass-through and read-data forwarding.
// If the image overruns DEPTH_WORDS, the block latches a sticky error.
// Only reset clears that error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; memory and fetch both quiet
// S_LOAD  | accepting loader words, one registered write per accept
// S_DRAIN | single cycle in which the final registered write lands
// S_RUN   | fetch stage owns memory; pc_addr and mem_rdata passed through
// S_ERROR | image overran memory; latched until reset
module imem_boot_arbiter #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic [31:0] pc_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] instr_out,
  output logic        cpu_run,
  output logic [15:0] load_count,
  output logic        err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_RUN,
    S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [15:0] count_q, count_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  // State, pointer, counter and registered write port; reset aborts any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a write request defaults low so a write lasts only one cycle.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          we_d    = 1'b1;
          addr_d  = {{(30-AW){1'b0}}, wptr_q, 2'b00};
          wdata_d = load_data;
          wptr_d  = wptr_q + 1'b1;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          if (load_last) begin
            state_d = S_DRAIN;
          end else if (wptr_q == WPTR_LAST) begin
            // The overflowing word is still written; it lands in the first ERROR cycle.
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
          count_d = '0;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode; during RUN the fetch stage drives the address directly.
  always_comb begin
    load_ready = (state_q == S_LOAD);
    cpu_run    = (state_q == S_RUN);
    mem_we     = we_q;
    mem_addr   = (state_q == S_RUN) ? pc_addr : addr_q;
    mem_wdata  = wdata_q;
    instr_out  = (state_q == S_RUN) ? mem_rdata : 32'h0000_0000;
    load_count = count_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Scoreboard bench for imem_boot_arbiter (DEPTH_WORDS=4 so overflow is reachable).
module tb_imem_boot_arbiter;

  localparam int TB_DEPTH = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_RUN = 3, P_ERROR = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] pc_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] instr_out;
  logic        cpu_run;
  logic [15:0] load_count;
  logic        err;

  imem_boot_arbiter #(.DEPTH_WORDS(TB_DEPTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pc_addr    (pc_addr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .instr_out  (instr_out),
    .cpu_run    (cpu_run),
    .load_count (load_count),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          m_phase = P_IDLE;
  int          m_count = 0;
  int          m_wptr = 0;
  logic [31:0] last_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the phase, count and write pointer from the spec rules.
  // Each accepted word queues the write that must appear in the next cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE;
      m_count = 0;
      m_wptr  = 0;
      exp_q.delete();
    end else begin
      cyc++;
      case (m_phase)
        P_IDLE, P_RUN: begin
          if (start) begin
            m_phase = P_LOAD;
            m_count = 0;
            m_wptr  = 0;
          end
        end
        P_LOAD: begin
          if (load_valid) begin
            exp_q.push_back('{cyc, 32'(m_wptr * 4), load_data});
            if (m_count < 65535) m_count++;
            if (load_last) m_phase = P_DRAIN;
            else if (m_wptr == TB_DEPTH - 1) m_phase = P_ERROR;
            m_wptr++;
          end
        end
        P_DRAIN: m_phase = P_RUN;
        default: m_phase = P_ERROR;
      endcase
    end
  end

  // Monitor: compares the DUT against the model on each falling edge and pops writes as they appear.
  always @(negedge clk) begin
    if (!rst) begin
      last_addr = 32'h0;
      chk("reset_outputs",
          {20'h0, load_ready, mem_we, cpu_run, err, 8'h0} | mem_addr | mem_wdata | instr_out | 32'(load_count),
          32'h0);
    end else begin
      chk("cpu_run", 32'(cpu_run), 32'(m_phase == P_RUN));
      chk("load_ready", 32'(load_ready), 32'(m_phase == P_LOAD));
      chk("err", 32'(err), 32'(m_phase == P_ERROR));
      chk("load_count", 32'(load_count), 32'(m_count));
      chk("instr_out", instr_out, (m_phase == P_RUN) ? mem_rdata : 32'h0);
      if (m_phase == P_RUN) chk("run_mem_addr", mem_addr, pc_addr);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_we), 32'h0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
          chk("write_addr", mem_addr, e.addr);
          chk("write_data", mem_wdata, e.data);
          last_addr = e.addr;
        end
      end else begin
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("missing_write", 32'(mem_we), 32'h1);
          void'(exp_q.pop_front());
        end
        if (m_phase != P_RUN) chk("hold_mem_addr", mem_addr, last_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_now(input string name);
    chk(name, {27'h0, load_ready, mem_we, cpu_run, err, 1'b0} | mem_addr | mem_wdata | instr_out | 32'(load_count), 32'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
    pc_addr = 32'h0; mem_rdata = 32'h0;
    #1;
    check_reset_now("reset_immediate");
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();

    // Three-word image, then fetch from PC 0x4.
    pulse_start();
    word(32'h00500093, 1'b0);
    word(32'h00100113, 1'b0);
    word(32'h002081B3, 1'b1);
    tick();
    pc_addr = 32'h4; mem_rdata = 32'h00100113;
    repeat (3) tick();
    chk("count_after_load3", 32'(load_count), 32'd3);

    // Reload from RUN with a single-word image.
    pulse_start();
    word(32'hDEADBEEF, 1'b1);
    repeat (3) tick();
    chk("count_after_reload", 32'(load_count), 32'd1);

    // Valid toggling 1,0,1.
    pulse_start();
    word(32'h11111111, 1'b0);
    tick();
    word(32'h22222222, 1'b1);
    repeat (3) tick();

    // Overflow: five words without last into four-word memory.
    pulse_start();
    for (int i = 0; i < 5; i++) word($urandom, 1'b0);
    start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    tick();
    chk("err_latched", 32'(err), 32'h1);
    rst = 1'b0;
    #1;
    check_reset_now("reset_from_error");
    tick();
    rst = 1'b1;
    tick();

    // Reset after two accepted words.
    pulse_start();
    word(32'hAAAA0000, 1'b0);
    load_valid = 1'b1; load_data = 32'hAAAA0001;
    tick();
    load_data = 32'hAAAA0002;
    rst = 1'b0;
    #1;
    check_reset_now("reset_mid_load");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (2) tick();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      start      = ($urandom_range(0, 7) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_last  = ($urandom_range(0, 3) == 0);
      load_data  = $urandom;
      pc_addr    = {$urandom_range(0, 255), 2'b00};
      mem_rdata  = $urandom;
      rst        = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    repeat (4) tick();
    chk("pending_writes", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
